// File: rtl/max_pool2x2.sv
// Streaming 2x2 / stride-2 signed max-pooling over one raster-ordered plane.
// Even rows leave horizontal pair maxima in a half-width line buffer; odd rows finish each window.
module max_pool2x2 #(
  parameter int DWIDTH = 16,
  parameter int MAXW   = 32,
  parameter int MAXH   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [$clog2(MAXW+1)-1:0] img_w,
  input  logic [$clog2(MAXH+1)-1:0] img_h,
  input  logic                      in_valid,
  input  logic [DWIDTH-1:0]         in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [DWIDTH-1:0]         out_data,
  output logic                      busy,
  output logic                      done
);

  localparam int WW  = $clog2(MAXW+1);
  localparam int HW  = $clog2(MAXH+1);
  localparam int LBD = MAXW / 2;
  localparam int LBW = (LBD > 1) ? $clog2(LBD) : 1;
  localparam logic [WW-1:0] W_ONE = WW'(1);
  localparam logic [HW-1:0] H_ONE = HW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t              state_q;
  logic [WW-1:0]       w_q;
  logic [HW-1:0]       h_q;
  logic [WW-1:0]       wlast_q;
  logic [HW-1:0]       hlast_q;
  logic [WW-1:0]       col_q;
  logic [HW-1:0]       row_q;
  logic [DWIDTH-1:0]   hreg_q;
  logic                in_ready_q;
  logic                busy_q;
  logic                out_valid_q;
  logic [DWIDTH-1:0]   out_data_q;
  logic                done_q;
  logic [DWIDTH-1:0]   lbuf [LBD];

  logic                acc_s;
  logic                pooled_s;
  logic                last_col_s;
  logic                last_s;
  logic                lb_we_s;
  logic                emit_s;
  logic                empty_s;
  logic [WW-1:0]       w_start_s;
  logic [HW-1:0]       h_start_s;
  logic [LBW-1:0]      lb_idx_s;
  logic [DWIDTH-1:0]   lb_rd_s;
  logic [DWIDTH-1:0]   pair_s;
  logic [DWIDTH-1:0]   win_s;

  function automatic logic [DWIDTH-1:0] smax(input logic [DWIDTH-1:0] a,
                                             input logic [DWIDTH-1:0] b);
    if ($signed(a) >= $signed(b)) begin
      smax = a;
    end else begin
      smax = b;
    end
  endfunction

  // Handshake, pooled-region decode and window arithmetic for the current pixel.
  always_comb begin
    w_start_s  = {img_w[WW-1:1], 1'b0};
    h_start_s  = {img_h[HW-1:1], 1'b0};
    empty_s    = (w_start_s == {WW{1'b0}}) || (h_start_s == {HW{1'b0}});
    acc_s      = in_valid && in_ready_q;
    pooled_s   = (col_q < w_q) && (row_q < h_q);
    last_col_s = (col_q == wlast_q);
    last_s     = last_col_s && (row_q == hlast_q);
    lb_idx_s   = col_q[LBW:1];
    lb_rd_s    = lbuf[lb_idx_s];
    pair_s     = smax(hreg_q, in_data);
    win_s      = smax(lb_rd_s, pair_s);
    lb_we_s    = acc_s && pooled_s && col_q[0] && !row_q[0];
    emit_s     = acc_s && pooled_s && col_q[0] && row_q[0];
  end

  // Line buffer: written on even rows before the odd row reads it, so it carries no reset.
  always_ff @(posedge clk) begin
    if (lb_we_s) begin
      lbuf[lb_idx_s] <= pair_s;
    end
  end

  // Control FSM, raster counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      w_q         <= {WW{1'b0}};
      h_q         <= {HW{1'b0}};
      wlast_q     <= {WW{1'b0}};
      hlast_q     <= {HW{1'b0}};
      col_q       <= {WW{1'b0}};
      row_q       <= {HW{1'b0}};
      hreg_q      <= {DWIDTH{1'b0}};
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {DWIDTH{1'b0}};
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            w_q     <= w_start_s;
            h_q     <= h_start_s;
            wlast_q <= img_w - W_ONE;
            hlast_q <= img_h - H_ONE;
            col_q   <= {WW{1'b0}};
            row_q   <= {HW{1'b0}};
            if (empty_s) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_RUN;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (acc_s) begin
            if (last_col_s) begin
              col_q <= {WW{1'b0}};
              row_q <= row_q + H_ONE;
            end else begin
              col_q <= col_q + W_ONE;
            end
            if (pooled_s && !col_q[0]) begin
              hreg_q <= in_data;
            end
            if (emit_s) begin
              out_valid_q <= 1'b1;
              out_data_q  <= win_s;
            end
            // Odd trailing row/column pixels are still counted, so the plane ends on img_w*img_h.
            if (last_s) begin
              state_q    <= S_FIN;
              done_q     <= 1'b1;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
            end
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;

endmodule

// File: tb/tb_max_pool2x2.sv
// Self-checking bench for max_pool2x2: table of 2x2 windows, directed planes,
// randomized planes against a whole-plane reference model, and reset/start corner cases.
module tb_max_pool2x2;

  localparam int DW   = 16;
  localparam int MAXW = 32;
  localparam int MAXH = 32;
  localparam int WW   = $clog2(MAXW+1);
  localparam int HW   = $clog2(MAXH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [WW-1:0] img_w;
  logic [HW-1:0] img_h;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  max_pool2x2 #(.DWIDTH(DW), .MAXW(MAXW), .MAXH(MAXH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .img_w    (img_w),
    .img_h    (img_h),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p0;
    int p1;
    int p2;
    int p3;
    int exp;
  } win_t;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  int pix_q[$];
  int got_val[$];
  int got_cyc[$];
  int acc_cyc[$];
  int done_cyc;
  int n_acc;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Advance one clock; everything after this is sampled 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic sample(output int d_busy, output int d_rdy);
    d_busy = -1;
    d_rdy  = -1;
    if (out_valid) begin
      got_val.push_back(int'($signed(out_data)));
      got_cyc.push_back(cyc);
    end
    if (done && done_cyc < 0) begin
      done_cyc = cyc;
      d_busy   = int'(busy);
      d_rdy    = int'(in_ready);
    end
  endtask

  // Runs one plane from pix_q with random in_valid gaps and checks it against the model.
  task automatic run_plane(input int w, input int h, input int gap_max,
                           input bit mid_start, input string tag);
    int  exp_val[$];
    int  exp_idx[$];
    int  wp, hp, npix, budget, start_cyc, gap, m, b0, r0, db, dr;
    bit  poked;
    got_val.delete();
    got_cyc.delete();
    acc_cyc.delete();
    wp = w - (w % 2);
    hp = h - (h % 2);
    npix = (wp == 0 || hp == 0) ? 0 : w * h;
    for (int r = 0; r < hp / 2; r++) begin
      for (int c = 0; c < wp / 2; c++) begin
        m = pix_q[(2*r)*w + 2*c];
        if (pix_q[(2*r)*w + 2*c + 1] > m) m = pix_q[(2*r)*w + 2*c + 1];
        if (pix_q[(2*r+1)*w + 2*c] > m) m = pix_q[(2*r+1)*w + 2*c];
        if (pix_q[(2*r+1)*w + 2*c + 1] > m) m = pix_q[(2*r+1)*w + 2*c + 1];
        exp_val.push_back(m);
        exp_idx.push_back((2*r+1)*w + 2*c + 1);
      end
    end

    done_cyc = -1;
    n_acc    = 0;
    db       = -1;
    dr       = -1;
    poked    = 1'b0;
    start    = 1'b1;
    img_w    = WW'(w);
    img_h    = HW'(h);
    in_valid = 1'b0;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    sample(b0, r0);
    if (b0 >= 0) begin db = b0; dr = r0; end
    gap    = 0;
    budget = npix * 5 + 40;
    while (done_cyc < 0 && budget > 0) begin
      if (gap > 0) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        gap--;
      end else begin
        in_valid = (n_acc < npix);
        in_data  = (n_acc < npix) ? DW'(pix_q[n_acc]) : DW'($urandom);
      end
      if (mid_start && !poked && n_acc == npix / 2) begin
        start = 1'b1;
        img_w = WW'(2);
        img_h = HW'(2);
        poked = 1'b1;
      end
      if (in_valid && in_ready) begin
        acc_cyc.push_back(cyc);
        n_acc++;
        gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      end
      tick();
      start = 1'b0;
      sample(b0, r0);
      if (b0 >= 0) begin db = b0; dr = r0; end
      budget--;
    end
    in_valid = 1'b0;

    check({tag, " done seen"}, int'(done_cyc >= 0), 1);
    check({tag, " accepted"}, n_acc, npix);
    if (npix == 0) check({tag, " done latency"}, done_cyc, start_cyc + 1);
    else if (n_acc == npix) check({tag, " done latency"}, done_cyc, acc_cyc[npix-1] + 1);
    check({tag, " busy at done"}, db, 0);
    check({tag, " in_ready at done"}, dr, 0);
    check({tag, " out count"}, got_val.size(), exp_val.size());
    for (int k = 0; k < got_val.size() && k < exp_val.size(); k++) begin
      check($sformatf("%s out[%0d] value", tag, k), got_val[k], exp_val[k]);
      if (exp_idx[k] < acc_cyc.size())
        check($sformatf("%s out[%0d] cycle", tag, k), got_cyc[k], acc_cyc[exp_idx[k]] + 1);
    end

    // FIN cycle: in_valid and a start must both be ignored.
    in_valid = 1'b1;
    in_data  = DW'($urandom);
    start    = 1'b1;
    img_w    = WW'(2);
    img_h    = HW'(2);
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    check({tag, " post-FIN out_valid"}, int'(out_valid), 0);
    check({tag, " post-FIN busy"}, int'(busy), 0);
    check({tag, " post-FIN in_ready"}, int'(in_ready), 0);
    check({tag, " post-FIN done"}, int'(done), 0);
  endtask

  win_t tbl[6];
  int   quiet;
  int   rw, rh;

  initial begin
    tbl[0] = '{-3, -7, -1, -32768, -1};
    tbl[1] = '{-5, -5, -5, -5, -5};
    tbl[2] = '{1, 2, 3, 4, 4};
    tbl[3] = '{32767, -32768, 0, 0, 32767};
    tbl[4] = '{-32768, -32768, -32768, -32767, -32767};
    tbl[5] = '{9, 100, -100, 99, 100};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; img_w = '0; img_h = '0;
    tick();
    tick();
    check("reset in_ready", int'(in_ready), 0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_data", int'(out_data), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 6; k++) begin
      pix_q.delete();
      pix_q.push_back(tbl[k].p0);
      pix_q.push_back(tbl[k].p1);
      pix_q.push_back(tbl[k].p2);
      pix_q.push_back(tbl[k].p3);
      run_plane(2, 2, 0, 1'b0, $sformatf("tbl%0d", k));
      check($sformatf("tbl%0d window", k), (got_val.size() > 0) ? got_val[0] : 99999, tbl[k].exp);
    end

    pix_q.delete();
    for (int i = 0; i < 16; i++) pix_q.push_back(i);
    run_plane(4, 4, 0, 1'b0, "ramp4x4");
    if (got_val.size() == 4) begin
      check("ramp4x4 seq0", got_val[0], 5);
      check("ramp4x4 seq1", got_val[1], 7);
      check("ramp4x4 seq2", got_val[2], 13);
      check("ramp4x4 seq3", got_val[3], 15);
      check("ramp4x4 done with last out", got_cyc[3], done_cyc);
    end else begin
      check("ramp4x4 seq length", got_val.size(), 4);
    end

    run_plane(4, 4, 3, 1'b1, "gaps4x4");
    if (got_val.size() == 4) check("gaps4x4 seq3", got_val[3], 15);

    pix_q.delete();
    for (int i = 0; i < 2 * MAXW; i++) pix_q.push_back(i);
    run_plane(MAXW, 2, 0, 1'b0, "fullwidth");
    if (got_val.size() == MAXW / 2) check("fullwidth last", got_val[MAXW/2-1], 2 * MAXW - 1);

    pix_q.delete();
    for (int i = 0; i < 20; i++) pix_q.push_back((i % 5 == 4) ? 30000 : i);
    run_plane(5, 4, 1, 1'b0, "odd5x4");

    pix_q.delete();
    for (int i = 0; i < 9; i++) pix_q.push_back(50 - i);
    run_plane(3, 3, 0, 1'b0, "odd3x3");

    pix_q.delete();
    run_plane(0, 4, 0, 1'b0, "zero");

    for (int t = 0; t < 5; t++) begin
      rw = int'($urandom_range(2, MAXW));
      rh = int'($urandom_range(2, 8));
      pix_q.delete();
      for (int i = 0; i < rw * rh; i++) begin
        if (t % 2 == 1) pix_q.push_back(int'($urandom_range(0, 3)) - 2);
        else pix_q.push_back(int'($urandom_range(0, 65535)) - 32768);
      end
      run_plane(rw, rh, t % 4, (t == 2), $sformatf("rand%0d_%0dx%0d", t, rw, rh));
    end

    // Abort a plane with reset after it has produced an output.
    start = 1'b1; img_w = WW'(4); img_h = HW'(4);
    tick();
    start = 1'b0;
    for (int j = 0; j < 7; j++) begin
      in_valid = 1'b1;
      in_data  = DW'(100 + j);
      tick();
      if (j == 5) begin
        check("abort pre out_valid", int'(out_valid), 1);
        check("abort pre out_data", int'($signed(out_data)), 105);
      end
    end
    rst = 1'b1;
    tick();
    check("abort in_ready", int'(in_ready), 0);
    check("abort out_valid", int'(out_valid), 0);
    check("abort out_data", int'(out_data), 0);
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    rst = 1'b0;
    in_valid = 1'b0;
    quiet = 0;
    for (int j = 0; j < 4; j++) begin
      tick();
      if (done || busy || out_valid) quiet++;
    end
    check("abort no done afterwards", quiet, 0);
    pix_q.delete();
    for (int i = 1; i <= 4; i++) pix_q.push_back(i);
    run_plane(2, 2, 0, 1'b0, "after_abort");
    check("after_abort value", (got_val.size() > 0) ? got_val[0] : 99999, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
